// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port data RAM with a small MMIO register window.
// Word RAM at byte 0..DEPTH*4-1, TOHOST at MMIO_BASE+0x0, STATUS at MMIO_BASE+0x8.
// Optional macro DATA_MEM_CYCLE_CNT_EN adds a CYCLE counter at MMIO_BASE+0x4.
// Reads have one cycle of latency; a simultaneous read and write returns the old word.

`ifndef XLEN
`define XLEN 32
`endif

module data_mem_resp #(
  parameter int                DEPTH     = 1024,
  parameter logic [`XLEN-1:0]  MMIO_BASE = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [`XLEN-1:0]  mem_addr_i,
  input  logic              mem_read_en_i,
  input  logic              mem_write_en_i,
  input  logic [`XLEN-1:0]  mem_write_data_i,
  output logic [`XLEN-1:0]  mem_read_data_o,
  output logic              mem_read_valid_o,
  output logic [`XLEN-1:0]  tohost_o,
  output logic              tohost_valid_o,
  output logic              fault_o
);

  localparam int               AW          = $clog2(DEPTH);
  localparam logic [`XLEN-1:0] TOHOST_ADDR = MMIO_BASE;
  localparam logic [`XLEN-1:0] STATUS_ADDR = MMIO_BASE + `XLEN'(8);
`ifdef DATA_MEM_CYCLE_CNT_EN
  localparam logic [`XLEN-1:0] CYCLE_ADDR  = MMIO_BASE + `XLEN'(4);
`endif

  logic [`XLEN-1:0] mem [DEPTH];

  logic             access;
  logic             misaligned;
  logic             in_ram;
  logic             hit_tohost;
  logic             hit_status;
  logic             mapped;
  logic             fault_set;
  logic             ram_we;
  logic [AW-1:0]    word_idx;
  logic [`XLEN-1:0] rdata_next;

`ifdef DATA_MEM_CYCLE_CNT_EN
  logic             hit_cycle;
  logic [`XLEN-1:0] cycle_cnt;
`endif

  // Decode the address and select the value a read would return this cycle.
  always_comb begin
    access     = mem_read_en_i | mem_write_en_i;
    misaligned = mem_addr_i[1:0] != 2'b00;
    in_ram     = mem_addr_i[`XLEN-1:AW+2] == '0;
    word_idx   = mem_addr_i[AW+1:2];
    hit_tohost = mem_addr_i == TOHOST_ADDR;
    hit_status = mem_addr_i == STATUS_ADDR;
`ifdef DATA_MEM_CYCLE_CNT_EN
    hit_cycle  = mem_addr_i == CYCLE_ADDR;
    mapped     = !misaligned && (in_ram || hit_tohost || hit_status || hit_cycle);
`else
    mapped     = !misaligned && (in_ram || hit_tohost || hit_status);
`endif
    fault_set  = access && !mapped;
    // Writes issued while reset is held are dropped so RAM sees no in-flight update.
    ram_we     = mem_write_en_i && mapped && in_ram && !rst_i;

    rdata_next = '0;
    if (mapped) begin
      if (in_ram) begin
        rdata_next = mem[word_idx];
      end else if (hit_tohost) begin
        rdata_next = tohost_o;
      end else if (hit_status) begin
        rdata_next = {{(`XLEN-1){1'b0}}, fault_o};
`ifdef DATA_MEM_CYCLE_CNT_EN
      end else if (hit_cycle) begin
        rdata_next = cycle_cnt;
`endif
      end
    end
  end

  // RAM array write port; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      mem[word_idx] <= mem_write_data_i;
    end
  end

  // Read response, TOHOST register and sticky fault flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_read_data_o  <= '0;
      mem_read_valid_o <= 1'b0;
      tohost_o         <= '0;
      tohost_valid_o   <= 1'b0;
      fault_o          <= 1'b0;
    end else begin
      mem_read_valid_o <= mem_read_en_i;
      if (mem_read_en_i) begin
        mem_read_data_o <= rdata_next;
      end
      tohost_valid_o <= mem_write_en_i && hit_tohost && mapped && !in_ram;
      if (mem_write_en_i && hit_tohost && mapped && !in_ram) begin
        tohost_o <= mem_write_data_i;
      end
      if (fault_set) begin
        fault_o <= 1'b1;
      end else if (mem_write_en_i && hit_status && mapped && !in_ram) begin
        fault_o <= 1'b0;
      end
    end
  end

`ifdef DATA_MEM_CYCLE_CNT_EN
  // Free-running cycle counter; a write reloads it and counting resumes next edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt <= '0;
    end else if (mem_write_en_i && hit_cycle && mapped && !in_ram) begin
      cycle_cnt <= mem_write_data_i;
    end else begin
      cycle_cnt <= cycle_cnt + `XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed self-checking bench for data_mem_resp.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.

module tb_data_mem_resp;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [31:0] TOHOST    = MMIO_BASE;
  localparam logic [31:0] CYCLE     = MMIO_BASE + 32'h4;
  localparam logic [31:0] STATUS    = MMIO_BASE + 32'h8;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] tohost;
  logic        tohost_valid;
  logic        fault;

  int checks;
  int passes;

  data_mem_resp #(
    .DEPTH     (1024),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .mem_addr_i       (addr),
    .mem_read_en_i    (rd_en),
    .mem_write_en_i   (wr_en),
    .mem_write_data_i (wdata),
    .mem_read_data_o  (rdata),
    .mem_read_valid_o (rvalid),
    .tohost_o         (tohost),
    .tohost_valid_o   (tohost_valid),
    .fault_o          (fault)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Present one access for a single rising edge, then drop the enables.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd_en = rd;
    wr_en = wr;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  // Let one rising edge pass with both enables low.
  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Directed test sequence.
  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    addr   = '0;
    wdata  = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_rvalid", {31'b0, rvalid}, 32'h0);
    checkOutput("reset_tohost", tohost, 32'h0);
    checkOutput("reset_tohost_valid", {31'b0, tohost_valid}, 32'h0);
    checkOutput("reset_fault", {31'b0, fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back, one-cycle latency and one-cycle valid pulse.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
    checkOutput("write_no_valid", {31'b0, rvalid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("read10_data", rdata, 32'hCAFE_F00D);
    checkOutput("read10_valid", {31'b0, rvalid}, 32'h1);
    idleCycle();
    checkOutput("read10_valid_drop", {31'b0, rvalid}, 32'h0);
    checkOutput("read10_data_hold", rdata, 32'hCAFE_F00D);

    // Read-before-write on the same word.
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h1111_1111);
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h2222_2222);
    checkOutput("rbw_old_data", rdata, 32'h1111_1111);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    checkOutput("rbw_new_data", rdata, 32'h2222_2222);

    // Highest RAM word is in range.
    applyStimulus(1'b0, 1'b1, 32'hFFC, 32'hA5A5_5A5A);
    applyStimulus(1'b1, 1'b0, 32'hFFC, 32'h0);
    checkOutput("last_word_data", rdata, 32'hA5A5_5A5A);
    checkOutput("last_word_no_fault", {31'b0, fault}, 32'h0);

    // Misaligned write: no RAM change, sticky fault, STATUS read and clear.
    applyStimulus(1'b0, 1'b1, 32'h13, 32'hDEAD_BEEF);
    checkOutput("misaligned_wr_fault", {31'b0, fault}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("misaligned_wr_ram_intact", rdata, 32'hCAFE_F00D);
    checkOutput("fault_sticky", {31'b0, fault}, 32'h1);
    applyStimulus(1'b1, 1'b0, STATUS, 32'h0);
    checkOutput("status_read_one", rdata, 32'h1);
    applyStimulus(1'b0, 1'b1, STATUS, 32'h0);
    checkOutput("status_clear", {31'b0, fault}, 32'h0);
    applyStimulus(1'b1, 1'b0, STATUS, 32'h0);
    checkOutput("status_read_zero", rdata, 32'h0);

    // Misaligned read returns zero with valid.
    applyStimulus(1'b1, 1'b0, 32'h11, 32'h0);
    checkOutput("misaligned_rd_data", rdata, 32'h0);
    checkOutput("misaligned_rd_valid", {31'b0, rvalid}, 32'h1);
    checkOutput("misaligned_rd_fault", {31'b0, fault}, 32'h1);
    applyStimulus(1'b0, 1'b1, STATUS, 32'h0);

    // First byte address past the RAM is unmapped.
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0);
    checkOutput("oob_rd_data", rdata, 32'h0);
    checkOutput("oob_rd_valid", {31'b0, rvalid}, 32'h1);
    checkOutput("oob_rd_fault", {31'b0, fault}, 32'h1);
    applyStimulus(1'b0, 1'b1, STATUS, 32'h0);
    checkOutput("oob_clear", {31'b0, fault}, 32'h0);

    // TOHOST write pulses once and reads back.
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h0000_0001);
    checkOutput("tohost_value", tohost, 32'h1);
    checkOutput("tohost_pulse", {31'b0, tohost_valid}, 32'h1);
    idleCycle();
    checkOutput("tohost_pulse_drop", {31'b0, tohost_valid}, 32'h0);
    checkOutput("tohost_hold", tohost, 32'h1);
    applyStimulus(1'b1, 1'b0, TOHOST, 32'h0);
    checkOutput("tohost_readback", rdata, 32'h1);

`ifdef DATA_MEM_CYCLE_CNT_EN
    // Counter reload then wrap through all-ones to zero.
    applyStimulus(1'b0, 1'b1, CYCLE, 32'hFFFF_FFFE);
    checkOutput("cycle_wr_no_fault", {31'b0, fault}, 32'h0);
    applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
    checkOutput("cycle_after_load", rdata, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
    checkOutput("cycle_all_ones", rdata, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
    checkOutput("cycle_wrap", rdata, 32'h0);
`else
    // Without the counter the CYCLE address is unmapped.
    applyStimulus(1'b0, 1'b1, CYCLE, 32'hFFFF_FFFE);
    checkOutput("cycle_unmapped_fault", {31'b0, fault}, 32'h1);
    applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
    checkOutput("cycle_unmapped_data", rdata, 32'h0);
`endif

    // Leave a fault pending so reset is seen to clear it.
    applyStimulus(1'b0, 1'b1, 32'h2000, 32'h0);
    checkOutput("pre_reset_fault", {31'b0, fault}, 32'h1);

    // Reset lands between the request and the response edge; write must be dropped.
    @(negedge clk);
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 32'h10;
    wdata = 32'h1234_5678;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_fault", {31'b0, fault}, 32'h0);
    checkOutput("async_rst_tohost", tohost, 32'h0);
    checkOutput("async_rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_rvalid", {31'b0, rvalid}, 32'h0);
    checkOutput("rst_tohost_valid", {31'b0, tohost_valid}, 32'h0);
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // First edge after release accepts the read; RAM kept its contents.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("post_rst_ram", rdata, 32'hCAFE_F00D);
    checkOutput("post_rst_valid", {31'b0, rvalid}, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
